inference_controller: RTL and testbench
=======================================

INFERENCE_CONTROLLER -- requirements
Module: inference_controller

Interface
REQ-001 SHALL have parameter M, default 8, width of class address/digit.
REQ-002 SHALL have parameter IMG_W, default 16, width of image count/index.
REQ-003 SHALL have parameter TIMEOUT, default 4096, max cycles per image in RUN before abort (>=2).
REQ-004 SHALL have ports:
  CLK  in  1  single clock, all logic on rising edge
  RST_N  in  1  reset, synchronous, active-low
  START  in  1  begin batch; sampled only in IDLE
  ABORT  in  1  terminate batch immediately
  NUM_IMAGES  in  IMG_W  images in batch, sampled on accepted START
  NEW_IMAGE  out  1  one-cycle clear pulse to decoder
  ENC_START  out  1  one-cycle start pulse to encoder
  ENC_DONE  in  1  encoder finished pushing current image
  DECODER_RDY  in  1  decoder final result valid (level)
  INFERED_DIGIT  in  M  decoder class output
  RESULT_VALID  out  1  result available
  RESULT_READY  in  1  consumer accepts result
  RESULT_DIGIT  out  M  class, or all-ones on timeout
  RESULT_TIMEOUT  out  1  result produced by timeout
  RESULT_CYCLES  out  IMG_W  RUN cycles spent on this image, saturating
  IMG_IDX  out  IMG_W  index of current image, 0-based
  BUSY  out  1  high in every state except IDLE
  BATCH_DONE  out  1  one-cycle pulse at batch completion

Function
REQ-005 SHALL implement FSM states IDLE, CLEAR, KICK, RUN, OUTPUT, DONE.
REQ-006 IDLE: START=1 with NUM_IMAGES>0 SHALL latch NUM_IMAGES, clear IMG_IDX, go CLEAR; START=1 with NUM_IMAGES=0 SHALL go DONE directly.
REQ-007 CLEAR SHALL assert NEW_IMAGE for exactly one cycle, then go KICK.
REQ-008 KICK SHALL assert ENC_START for exactly one cycle, clear cycle counter and enc_seen flag, then go RUN.
REQ-009 RUN SHALL set enc_seen when ENC_DONE=1, and increment cycle counter each cycle (saturating at all-ones).
REQ-010 RUN SHALL go OUTPUT when DECODER_RDY=1 and (enc_seen or ENC_DONE this cycle), capturing INFERED_DIGIT, RESULT_TIMEOUT=0, RESULT_CYCLES=counter+1.
REQ-011 RUN SHALL go OUTPUT with RESULT_DIGIT all-ones, RESULT_TIMEOUT=1, RESULT_CYCLES=TIMEOUT, when counter reaches TIMEOUT-1 without REQ-010 condition; REQ-010 wins if both occur in same cycle.
REQ-012 OUTPUT SHALL hold RESULT_VALID=1 and RESULT_* stable until RESULT_READY=1; transfer occurs on cycle both high.
REQ-013 On transfer: if IMG_IDX+1 == latched NUM_IMAGES SHALL go DONE, else increment IMG_IDX and go CLEAR.
REQ-014 DONE SHALL assert BATCH_DONE one cycle, then go IDLE; IMG_IDX retains last value.
REQ-015 RESULT_VALID SHALL be 0 in all states except OUTPUT; NEW_IMAGE, ENC_START, BATCH_DONE SHALL be 0 outside their states.
REQ-016 ABORT=1 in any non-IDLE state SHALL force IDLE next cycle, drop RESULT_VALID, no BATCH_DONE; ABORT has priority over all other transitions; ABORT in IDLE SHALL have no effect and block START that cycle.
REQ-017 START while BUSY SHALL be ignored.
REQ-018 ENC_DONE/DECODER_RDY outside RUN SHALL be ignored; enc_seen SHALL not carry over between images.

Reset
REQ-019 RST_N=0 at a rising edge SHALL force IDLE, IMG_IDX=0, counter=0, enc_seen=0, RESULT_DIGIT=0, RESULT_TIMEOUT=0, RESULT_CYCLES=0, all pulse/valid/BUSY outputs 0, regardless of state (including mid-batch).

Verification
REQ-020 NUM_IMAGES=3, each image: ENC_DONE 10 cycles after ENC_START, DECODER_RDY 20 cycles after with digits 7,2,9, RESULT_READY tied 1 -> three results 7,2,9, IMG_IDX 0,1,2, RESULT_TIMEOUT=0, one BATCH_DONE, NEW_IMAGE/ENC_START each pulse exactly 3 times.
REQ-021 TIMEOUT=16, NUM_IMAGES=1, DECODER_RDY never -> RESULT_DIGIT=8'hFF, RESULT_TIMEOUT=1, RESULT_CYCLES=16, then BATCH_DONE.
REQ-022 DECODER_RDY=1 before ENC_DONE -> no result until ENC_DONE; result on ENC_DONE cycle+1; DECODER_RDY and timeout same cycle -> RESULT_TIMEOUT=0.
REQ-023 RESULT_READY low 5 cycles in OUTPUT -> RESULT_VALID held 5+ cycles, RESULT_DIGIT stable, IMG_IDX unchanged until transfer.
REQ-024 ABORT during RUN of image 1 of 4, and RST_N=0 mid-OUTPUT -> IDLE next cycle, no BATCH_DONE, outputs at reset values; new START with NUM_IMAGES=0 -> BATCH_DONE 1 cycle later, no NEW_IMAGE.

Source files
------------

// File: rtl/inference_controller.sv
// Per-image inference sequencer: clears the decoder, kicks the encoder and collects one class result per image.
// Latency: CLEAR and KICK take one cycle each; the result registers one cycle after decoder-ready meets encoder-done (or timeout).
// Backpressure: OUTPUT holds RESULT_* stable until RESULT_READY; ABORT or RST_N=0 drop the batch without BATCH_DONE.
module inference_controller #(
  parameter int M       = 8,
  parameter int IMG_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [IMG_W-1:0] NUM_IMAGES,
  output logic             NEW_IMAGE,
  output logic             ENC_START,
  input  logic             ENC_DONE,
  input  logic             DECODER_RDY,
  input  logic [M-1:0]     INFERED_DIGIT,
  output logic             RESULT_VALID,
  input  logic             RESULT_READY,
  output logic [M-1:0]     RESULT_DIGIT,
  output logic             RESULT_TIMEOUT,
  output logic [IMG_W-1:0] RESULT_CYCLES,
  output logic [IMG_W-1:0] IMG_IDX,
  output logic             BUSY,
  output logic             BATCH_DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_KICK, S_RUN, S_OUTPUT, S_DONE
  } state_t;

  typedef struct packed {
    logic [M-1:0]     digit;
    logic             timeout;
    logic [IMG_W-1:0] cycles;
  } result_t;

  // Counter value of the last RUN cycle allowed before the image is abandoned.
  localparam logic [IMG_W-1:0] CNT_LAST = IMG_W'(TIMEOUT - 1);
  localparam logic [IMG_W-1:0] CNT_TO   = IMG_W'(TIMEOUT);
  localparam logic [IMG_W-1:0] CNT_MAX  = '1;
  localparam logic [IMG_W-1:0] CNT_ONE  = {{(IMG_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [IMG_W-1:0] num_q;
  logic [IMG_W-1:0] idx_q;
  logic [IMG_W-1:0] cnt_q;
  logic             enc_seen_q;
  result_t          res_q;

  logic             kill;
  logic             infer_hit;
  logic             cnt_hit;
  logic             last_img;
  logic [IMG_W-1:0] cnt_inc;

  // ABORT only matters once a batch is in flight; in IDLE it merely masks START.
  assign kill      = ABORT && (state_q != S_IDLE);
  // A decoder result is only trusted once the encoder has finished this image.
  assign infer_hit = DECODER_RDY && (enc_seen_q || ENC_DONE);
  assign cnt_hit   = (cnt_q == CNT_LAST);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign last_img  = ({1'b0, idx_q} + {{IMG_W{1'b0}}, 1'b1}) == {1'b0, num_q};

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection; ABORT overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (START && !ABORT) state_d = (NUM_IMAGES == '0) ? S_DONE : S_CLEAR;
        S_CLEAR:  state_d = S_KICK;
        S_KICK:   state_d = S_RUN;
        S_RUN:    if (infer_hit || cnt_hit) state_d = S_OUTPUT;
        S_OUTPUT: if (RESULT_READY) state_d = last_img ? S_DONE : S_CLEAR;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    NEW_IMAGE    = (state_q == S_CLEAR);
    ENC_START    = (state_q == S_KICK);
    RESULT_VALID = (state_q == S_OUTPUT);
    BATCH_DONE   = (state_q == S_DONE);
    BUSY         = (state_q != S_IDLE);
  end

  // Batch bookkeeping, per-image cycle counter and the captured result.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      num_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      enc_seen_q <= 1'b0;
      res_q      <= '0;
    end else if (!kill) begin
      case (state_q)
        S_IDLE: begin
          if (START && !ABORT && (NUM_IMAGES != '0)) begin
            num_q <= NUM_IMAGES;
            idx_q <= '0;
          end
        end
        S_KICK: begin
          cnt_q      <= '0;
          enc_seen_q <= 1'b0;
        end
        S_RUN: begin
          if (ENC_DONE) enc_seen_q <= 1'b1;
          cnt_q <= cnt_inc;
          if (infer_hit)
            res_q <= '{digit: INFERED_DIGIT, timeout: 1'b0, cycles: cnt_inc};
          else if (cnt_hit)
            res_q <= '{digit: {M{1'b1}}, timeout: 1'b1, cycles: CNT_TO};
        end
        S_OUTPUT: begin
          if (RESULT_READY && !last_img) idx_q <= idx_q + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign RESULT_DIGIT   = res_q.digit;
  assign RESULT_TIMEOUT = res_q.timeout;
  assign RESULT_CYCLES  = res_q.cycles;
  assign IMG_IDX        = idx_q;

endmodule

// File: tb/tb_inference_controller.sv
`timescale 1ns/1ps
module tb_inference_controller;
  localparam int M    = 8;
  localparam int W    = 16;
  localparam int TO_A = 4096;
  localparam int TO_B = 16;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic         ENC_DONE = 1'b0, DECODER_RDY = 1'b0, RESULT_READY = 1'b0;
  logic [W-1:0] NUM_IMAGES = '0;
  logic [M-1:0] INFERED_DIGIT = '0;

  logic new_a, enc_a, vld_a, to_a, busy_a, bd_a;
  logic new_b, enc_b, vld_b, to_b, busy_b, bd_b;
  logic [M-1:0] dig_a, dig_b;
  logic [W-1:0] cyc_a, cyc_b, idx_a, idx_b;

  always #5 CLK = ~CLK;

  inference_controller #(.M(M), .IMG_W(W), .TIMEOUT(TO_A)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .NUM_IMAGES(NUM_IMAGES),
    .NEW_IMAGE(new_a), .ENC_START(enc_a), .ENC_DONE(ENC_DONE), .DECODER_RDY(DECODER_RDY),
    .INFERED_DIGIT(INFERED_DIGIT), .RESULT_VALID(vld_a), .RESULT_READY(RESULT_READY),
    .RESULT_DIGIT(dig_a), .RESULT_TIMEOUT(to_a), .RESULT_CYCLES(cyc_a), .IMG_IDX(idx_a),
    .BUSY(busy_a), .BATCH_DONE(bd_a));

  inference_controller #(.M(M), .IMG_W(W), .TIMEOUT(TO_B)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .NUM_IMAGES(NUM_IMAGES),
    .NEW_IMAGE(new_b), .ENC_START(enc_b), .ENC_DONE(ENC_DONE), .DECODER_RDY(DECODER_RDY),
    .INFERED_DIGIT(INFERED_DIGIT), .RESULT_VALID(vld_b), .RESULT_READY(RESULT_READY),
    .RESULT_DIGIT(dig_b), .RESULT_TIMEOUT(to_b), .RESULT_CYCLES(cyc_b), .IMG_IDX(idx_b),
    .BUSY(busy_b), .BATCH_DONE(bd_b));

  // sel picks which instance the scenario observes (0: TIMEOUT=4096, 1: TIMEOUT=16).
  bit sel = 1'b0;
  wire         o_new  = sel ? new_b  : new_a;
  wire         o_enc  = sel ? enc_b  : enc_a;
  wire         o_vld  = sel ? vld_b  : vld_a;
  wire         o_to   = sel ? to_b   : to_a;
  wire         o_busy = sel ? busy_b : busy_a;
  wire         o_bd   = sel ? bd_b   : bd_a;
  wire [M-1:0] o_dig  = sel ? dig_b  : dig_a;
  wire [W-1:0] o_cyc  = sel ? cyc_b  : cyc_a;
  wire [W-1:0] o_idx  = sel ? idx_b  : idx_a;

  int vec = 0;
  int errs = 0;
  int n_new = 0, n_enc = 0, n_bd = 0;

  // Pulse-cycle counters for the observed instance.
  always @(negedge CLK) begin
    if (o_new) n_new <= n_new + 1;
    if (o_enc) n_enc <= n_enc + 1;
    if (o_bd)  n_bd  <= n_bd + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; START = 1'($urandom); ABORT = 1'($urandom);
    ENC_DONE = 1'($urandom); DECODER_RDY = 1'($urandom); NUM_IMAGES = W'($urandom);
    step(); step();
    RST_N = 1'b1; START = 1'b0; ABORT = 1'b0; ENC_DONE = 1'b0;
    DECODER_RDY = 1'b0; RESULT_READY = 1'b0;
  endtask

  task automatic start_batch(input int n);
    START = 1'b1; NUM_IMAGES = W'(n);
    step();
    START = 1'b0; NUM_IMAGES = W'($urandom);
  endtask

  // Reference: the image completes on the first RUN cycle where the decoder is ready and the
  // encoder has finished, i.e. cycle max(e,r); that must fall inside the first `to` RUN cycles.
  function automatic void model(input int to, input int e, input int r, input logic [M-1:0] d,
                                output logic [M-1:0] xd, output logic xto,
                                output logic [W-1:0] xc, output int xlat);
    int k;
    k = (e > r) ? e : r;
    if (k <= to - 1) begin xd = d; xto = 1'b0; xc = W'(k + 1); xlat = k + 2; end
    else begin xd = '1; xto = 1'b1; xc = W'(to); xlat = to + 1; end
  endfunction

  // Drives one image: ENC_DONE pulses on RUN cycle e, DECODER_RDY rises on RUN cycle r,
  // RESULT_READY is withheld for `hold` OUTPUT cycles. Returns at the cycle after the transfer.
  task automatic drive_image(input int e, input int r, input logic [M-1:0] d, input int hold,
                             output int lat, output logic [M-1:0] gd, output logic gto,
                             output logic [W-1:0] gc, output logic [W-1:0] gi,
                             output int nvld, output bit stable, output bit ok);
    int t;
    ok = 1'b1; stable = 1'b1; nvld = 0; lat = 0; gd = '0; gto = 1'b0; gc = '0; gi = '0;
    RESULT_READY = (hold == 0);
    t = 0;
    while (!o_enc && t < 100) begin step(); t++; end
    if (!o_enc) begin ok = 1'b0; return; end
    ENC_DONE = 1'($urandom); DECODER_RDY = 1'($urandom);
    t = 0;
    while (!o_vld && t < 200) begin
      step(); t++;
      ENC_DONE = ((t - 1) == e);
      DECODER_RDY = ((t - 1) >= r);
      INFERED_DIGIT = ((t - 1) >= r) ? d : M'($urandom);
    end
    ENC_DONE = 1'b0; DECODER_RDY = 1'($urandom);
    if (!o_vld) begin ok = 1'b0; DECODER_RDY = 1'b0; return; end
    lat = t; gd = o_dig; gto = o_to; gc = o_cyc; gi = o_idx;
    while (o_vld && nvld < 50) begin
      nvld++;
      if (o_dig !== gd || o_to !== gto || o_cyc !== gc || o_idx !== gi) stable = 1'b0;
      RESULT_READY = (nvld > hold);
      step();
    end
    RESULT_READY = 1'b0; DECODER_RDY = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    vec++;
    if ({new_a, enc_a, vld_a, to_a, busy_a, bd_a, dig_a, cyc_a, idx_a} !== '0) begin
      errs++;
      $display("FAIL reset_a: got %h want 0", {new_a, enc_a, vld_a, to_a, busy_a, bd_a, dig_a, cyc_a, idx_a});
    end
    vec++;
    if ({new_b, enc_b, vld_b, to_b, busy_b, bd_b, dig_b, cyc_b, idx_b} !== '0) begin
      errs++;
      $display("FAIL reset_b: got %h want 0", {new_b, enc_b, vld_b, to_b, busy_b, bd_b, dig_b, cyc_b, idx_b});
    end
  endtask

  task automatic test_batch3();
    logic [M-1:0] digs [3];
    int lat, nvld, b_new, b_enc, b_bd;
    logic [M-1:0] gd; logic gto; logic [W-1:0] gc, gi; bit st, ok;
    digs = '{8'd7, 8'd2, 8'd9};
    sel = 1'b0; do_reset();
    b_new = n_new; b_enc = n_enc; b_bd = n_bd;
    start_batch(3);
    for (int i = 0; i < 3; i++) begin
      drive_image(9, 29, digs[i], 0, lat, gd, gto, gc, gi, nvld, st, ok);
      vec++;
      if (!ok || gd !== digs[i] || gto !== 1'b0 || gc !== W'(30) || gi !== W'(i) || lat != 31 || nvld != 1) begin
        errs++;
        $display("FAIL batch3[%0d]: got ok=%b dig=%0d to=%b cyc=%0d idx=%0d lat=%0d nvld=%0d, want ok=1 dig=%0d to=0 cyc=30 idx=%0d lat=31 nvld=1",
                 i, ok, gd, gto, gc, gi, lat, nvld, digs[i], i);
      end
    end
    vec++;
    if (o_bd !== 1'b1) begin errs++; $display("FAIL batch3_done: BATCH_DONE=%b want 1", o_bd); end
    step();
    vec++;
    if (o_bd !== 1'b0 || o_busy !== 1'b0) begin
      errs++; $display("FAIL batch3_idle: BATCH_DONE=%b BUSY=%b want 0 0", o_bd, o_busy);
    end
    vec++;
    if (n_new - b_new != 3 || n_enc - b_enc != 3 || n_bd - b_bd != 1) begin
      errs++;
      $display("FAIL batch3_pulses: new=%0d enc=%0d done=%0d want 3 3 1", n_new - b_new, n_enc - b_enc, n_bd - b_bd);
    end
  endtask

  task automatic test_random();
    int n, e, r, hold, lat, nvld, xlat;
    logic [M-1:0] d, gd, xd; logic gto, xto; logic [W-1:0] gc, gi, xc; bit st, ok;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; do_reset();
      for (int b = 0; b < 4; b++) begin
        n = $urandom_range(1, 3);
        start_batch(n);
        for (int i = 0; i < n; i++) begin
          e = $urandom_range(0, s ? 24 : 40); r = $urandom_range(0, s ? 24 : 40);
          d = M'($urandom); hold = $urandom_range(0, 3);
          model(s ? TO_B : TO_A, e, r, d, xd, xto, xc, xlat);
          drive_image(e, r, d, hold, lat, gd, gto, gc, gi, nvld, st, ok);
          vec++;
          if (!ok || !st || gd !== xd || gto !== xto || gc !== xc || gi !== W'(i) || lat != xlat ||
              nvld != hold + 1 || ((i == n - 1) ? o_bd : o_new) !== 1'b1) begin
            errs++;
            $display("FAIL random[%0d.%0d.%0d] e=%0d r=%0d: got ok=%b st=%b dig=%h to=%b cyc=%0d idx=%0d lat=%0d nvld=%0d, want dig=%h to=%b cyc=%0d idx=%0d lat=%0d nvld=%0d",
                     s, b, i, e, r, ok, st, gd, gto, gc, gi, lat, nvld, xd, xto, xc, i, xlat, hold + 1);
          end
        end
        step();
      end
    end
  endtask

  task automatic test_timeout();
    int er [3][2];
    logic [M-1:0] xd [3];
    logic xto [3];
    int lat, nvld;
    logic [M-1:0] gd; logic gto; logic [W-1:0] gc, gi; bit st, ok;
    er = '{'{1000, 1000}, '{3, 15}, '{3, 16}};
    xd = '{8'hFF, 8'h5A, 8'hFF};
    xto = '{1'b1, 1'b0, 1'b1};
    sel = 1'b1; do_reset();
    for (int i = 0; i < 3; i++) begin
      start_batch(1);
      drive_image(er[i][0], er[i][1], 8'h5A, 0, lat, gd, gto, gc, gi, nvld, st, ok);
      vec++;
      if (!ok || gd !== xd[i] || gto !== xto[i] || gc !== W'(16) || lat != 17 || o_bd !== 1'b1) begin
        errs++;
        $display("FAIL timeout[%0d]: got ok=%b dig=%h to=%b cyc=%0d lat=%0d done=%b, want dig=%h to=%b cyc=16 lat=17 done=1",
                 i, ok, gd, gto, gc, lat, o_bd, xd[i], xto[i]);
      end
      step();
    end
  endtask

  task automatic test_rdy_before_enc();
    int lat, nvld;
    logic [M-1:0] gd; logic gto; logic [W-1:0] gc, gi; bit st, ok;
    sel = 1'b0; do_reset();
    start_batch(1);
    drive_image(12, 0, 8'h33, 0, lat, gd, gto, gc, gi, nvld, st, ok);
    vec++;
    if (!ok || gd !== 8'h33 || gto !== 1'b0 || gc !== W'(13) || lat != 14) begin
      errs++;
      $display("FAIL rdy_first: got ok=%b dig=%h to=%b cyc=%0d lat=%0d, want dig=33 to=0 cyc=13 lat=14", ok, gd, gto, gc, lat);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat, nvld;
    logic [M-1:0] d, gd; logic gto; logic [W-1:0] gc, gi; bit st, ok;
    sel = 1'b0; do_reset();
    start_batch(2);
    for (int i = 0; i < 2; i++) begin
      d = M'($urandom);
      drive_image(4, 6, d, 5, lat, gd, gto, gc, gi, nvld, st, ok);
      vec++;
      if (!ok || !st || nvld != 6 || gd !== d || gi !== W'(i) || gc !== W'(7)) begin
        errs++;
        $display("FAIL backpressure[%0d]: got ok=%b stable=%b nvld=%0d dig=%h idx=%0d cyc=%0d, want stable=1 nvld=6 dig=%h idx=%0d cyc=7",
                 i, ok, st, nvld, gd, gi, gc, d, i);
      end
    end
    step();
  endtask

  task automatic test_no_carry();
    int lat, nvld;
    logic [M-1:0] gd; logic gto; logic [W-1:0] gc, gi; bit st, ok;
    sel = 1'b1; do_reset();
    start_batch(2);
    drive_image(2, 5, 8'h11, 0, lat, gd, gto, gc, gi, nvld, st, ok);
    drive_image(1000, 0, 8'h22, 0, lat, gd, gto, gc, gi, nvld, st, ok);
    vec++;
    if (!ok || gd !== 8'hFF || gto !== 1'b1 || gc !== W'(16) || gi !== W'(1)) begin
      errs++;
      $display("FAIL no_carry: got ok=%b dig=%h to=%b cyc=%0d idx=%0d, want dig=ff to=1 cyc=16 idx=1", ok, gd, gto, gc, gi);
    end
    step();
  endtask

  task automatic test_abort();
    int t, b_bd, lat, nvld;
    logic [M-1:0] gd; logic gto; logic [W-1:0] gc, gi; bit st, ok;
    sel = 1'b0; do_reset();
    start_batch(4);
    drive_image(1, 2, 8'h44, 0, lat, gd, gto, gc, gi, nvld, st, ok);
    t = 0;
    while (!o_enc && t < 20) begin step(); t++; end
    vec++;
    if (o_enc !== 1'b1) begin errs++; $display("FAIL abort_kick: ENC_START=%b want 1", o_enc); end
    step(); step(); step();
    ABORT = 1'b1; DECODER_RDY = 1'b1; ENC_DONE = 1'b1;
    step();
    ABORT = 1'b0; DECODER_RDY = 1'b0; ENC_DONE = 1'b0;
    vec++;
    if (o_busy !== 1'b0 || o_vld !== 1'b0 || o_bd !== 1'b0) begin
      errs++; $display("FAIL abort_idle: BUSY=%b VALID=%b DONE=%b want 0 0 0", o_busy, o_vld, o_bd);
    end
    b_bd = n_bd;
    repeat (5) step();
    vec++;
    if (n_bd != b_bd || o_busy !== 1'b0) begin
      errs++; $display("FAIL abort_quiet: done pulses=%0d busy=%b want 0 0", n_bd - b_bd, o_busy);
    end
    ABORT = 1'b1; START = 1'b1; NUM_IMAGES = W'(2);
    step();
    ABORT = 1'b0; START = 1'b0;
    vec++;
    if (o_busy !== 1'b0 || o_new !== 1'b0 || o_bd !== 1'b0) begin
      errs++; $display("FAIL abort_blocks_start: BUSY=%b NEW=%b DONE=%b want 0 0 0", o_busy, o_new, o_bd);
    end
    start_batch(1);
    START = 1'b1; NUM_IMAGES = W'(5);
    step();
    START = 1'b0;
    drive_image(0, 0, 8'h66, 0, lat, gd, gto, gc, gi, nvld, st, ok);
    vec++;
    if (!ok || gd !== 8'h66 || o_bd !== 1'b1) begin
      errs++; $display("FAIL start_while_busy: ok=%b dig=%h DONE=%b want dig=66 DONE=1", ok, gd, o_bd);
    end
    step();
  endtask

  task automatic test_reset_mid_output();
    int t, b_new;
    sel = 1'b0; do_reset();
    start_batch(2);
    t = 0;
    while (!o_enc && t < 20) begin step(); t++; end
    ENC_DONE = 1'b1; DECODER_RDY = 1'b1; INFERED_DIGIT = 8'hA5; RESULT_READY = 1'b0;
    t = 0;
    while (!o_vld && t < 20) begin step(); t++; end
    ENC_DONE = 1'b0; DECODER_RDY = 1'b0;
    step(); step();
    vec++;
    if (o_vld !== 1'b1 || o_dig !== 8'hA5) begin
      errs++; $display("FAIL rst_mid_hold: VALID=%b dig=%h want 1 a5", o_vld, o_dig);
    end
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    vec++;
    if ({new_a, enc_a, vld_a, to_a, busy_a, bd_a, dig_a, cyc_a, idx_a} !== '0) begin
      errs++;
      $display("FAIL rst_mid_state: got %h want 0", {new_a, enc_a, vld_a, to_a, busy_a, bd_a, dig_a, cyc_a, idx_a});
    end
    b_new = n_new;
    START = 1'b1; NUM_IMAGES = '0;
    step();
    START = 1'b0;
    vec++;
    if (o_bd !== 1'b1 || o_busy !== 1'b1 || o_new !== 1'b0) begin
      errs++; $display("FAIL zero_batch_done: DONE=%b BUSY=%b NEW=%b want 1 1 0", o_bd, o_busy, o_new);
    end
    step();
    vec++;
    if (o_bd !== 1'b0 || o_busy !== 1'b0 || n_new != b_new) begin
      errs++; $display("FAIL zero_batch_idle: DONE=%b BUSY=%b new pulses=%0d want 0 0 0", o_bd, o_busy, n_new - b_new);
    end
  endtask

  initial begin
    test_reset();
    test_batch3();
    test_timeout();
    test_rdy_before_enc();
    test_backpressure();
    test_no_carry();
    test_abort();
    test_reset_mid_output();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
